// File: rtl/store_buffer.sv
// Posted-write store buffer between EX/MEM and data memory; owns the shared memory port.
// Optional STORE_BUFFER_FWD_EN: forward exact-match loads; without it any overlap stalls.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    st_valid,
    input  logic [ADDR_W-1:0]       st_addr,
    input  logic [DATA_W-1:0]       st_data,
    input  logic [2:0]              st_funct3,
    output logic                    st_ready,
    input  logic                    ld_valid,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic [2:0]              ld_funct3,
    output logic                    ld_hit,
    output logic [DATA_W-1:0]       ld_hit_data,
    output logic                    ld_stall,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    mem_write,
    output logic                    mem_read,
    output logic [2:0]              mem_funct3,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SPAN_W = ADDR_W + 1;
    localparam logic [2:0]  F3_W   = 3'b010;
    localparam logic [2:0]  F3_D   = 3'b011;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [2:0]        funct3;
    } entry_t;

    entry_t             buf_q [DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic               enq, drain, ld_ok, ovl_any;
`ifdef STORE_BUFFER_FWD_EN
    entry_t             newest;
    logic               exact;
`endif

    // Exclusive end of a byte span, one bit wider so the top of memory never wraps.
    function automatic logic [SPAN_W-1:0] span_end(input logic [ADDR_W-1:0] a, input logic [2:0] f3);
        return {1'b0, a} + ((f3 == F3_D) ? SPAN_W'(8) : SPAN_W'(4));
    endfunction

    function automatic logic overlaps(input logic [ADDR_W-1:0] ea, input logic [2:0] ef3,
                                      input logic [ADDR_W-1:0] la, input logic [2:0] lf3);
        return ({1'b0, la} < span_end(ea, ef3)) && ({1'b0, ea} < span_end(la, lf3));
    endfunction

    assign st_ready = (count_q != CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign ld_ok    = ld_valid && ((ld_funct3 == F3_W) || (ld_funct3 == F3_D));
    assign drain    = !ld_valid && !empty;
    // Unsupported store sizes are accepted but never enter the buffer.
    assign enq      = st_valid && st_ready && ((st_funct3 == F3_W) || (st_funct3 == F3_D));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq)   tail_q <= tail_q + PTR_W'(1);
            if (drain) head_q <= head_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(enq) - CNT_W'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) buf_q[tail_q] <= '{addr: st_addr, data: st_data, funct3: st_funct3};
    end

    // Scan oldest to newest so the last overlapping entry is the newest one.
    always_comb begin
        ovl_any = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
        newest  = '0;
`endif
        for (int i = 0; i < int'(DEPTH); i++) begin
            if ((CNT_W'(i) < count_q) &&
                overlaps(buf_q[head_q + PTR_W'(i)].addr, buf_q[head_q + PTR_W'(i)].funct3,
                         ld_addr, ld_funct3)) begin
                ovl_any = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                newest  = buf_q[head_q + PTR_W'(i)];
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign exact = ovl_any && (newest.addr == ld_addr) && (newest.funct3 == ld_funct3);
`endif

    // Load resolution and memory port arbitration; a load always owns the port.
    always_comb begin
        ld_hit      = 1'b0;
        ld_hit_data = '0;
        ld_stall    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_funct3  = '0;
        if (ld_ok) begin
            if (st_valid) begin
                ld_stall = 1'b1;
            end else if (!ovl_any) begin
                mem_read = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
            end else if (exact) begin
                ld_hit      = 1'b1;
                ld_hit_data = (ld_funct3 == F3_D) ? newest.data : DATA_W'(newest.data[31:0]);
`endif
            end else begin
                ld_stall = 1'b1;
            end
        end
        if (ld_valid) begin
            mem_addr   = ld_addr;
            mem_funct3 = ld_funct3;
        end else if (drain) begin
            mem_addr   = buf_q[head_q].addr;
            mem_wdata  = buf_q[head_q].data;
            mem_funct3 = buf_q[head_q].funct3;
            mem_write  = 1'b1;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: byte-level reference model, randomized and directed stimulus.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk, reset;
    logic        st_valid, st_ready, ld_valid;
    logic [63:0] st_addr, st_data, ld_addr;
    logic [2:0]  st_funct3, ld_funct3, mem_funct3;
    logic        ld_hit, ld_stall, mem_write, mem_read, empty;
    logic [63:0] ld_hit_data, mem_addr, mem_wdata;
    logic [2:0]  count;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
        .ld_hit(ld_hit), .ld_hit_data(ld_hit_data), .ld_stall(ld_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_funct3(mem_funct3), .empty(empty), .count(count)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [2:0]  f3;
    } st_t;

    typedef struct packed {
        logic        hit;
        logic        stall;
        logic        read;
        logic [63:0] data;
        logic [63:0] addr;
        logic [2:0]  f3;
    } ld_t;

    st_t model_q[$];
    st_t wr_q[$];
    ld_t ld_q[$];
    int  checks = 0;
    int  errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return (f3 == 3'b011) ? 8 : 4;
    endfunction

    // True if any byte address of span a equals any byte address of span b (no wrap).
    function automatic bit bytes_meet(input logic [63:0] a, input int na, input logic [63:0] b, input int nb);
        for (int i = 0; i < na; i++)
            for (int j = 0; j < nb; j++)
                if (({1'b0, a} + 65'(i)) == ({1'b0, b} + 65'(j))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic ld_t predict_load(input bit sv, input logic [63:0] la, input logic [2:0] lf);
        ld_t r;
        int  hit_idx;
        r = '0;
        r.addr = la;
        r.f3 = lf;
        if (lf != 3'b010 && lf != 3'b011) return r;
        if (sv) begin
            r.stall = 1'b1;
            return r;
        end
        hit_idx = -1;
        for (int k = model_q.size() - 1; k >= 0; k--) begin
            if (bytes_meet(la, nbytes(lf), model_q[k].addr, nbytes(model_q[k].f3))) begin
                hit_idx = k;
                break;
            end
        end
        if (hit_idx < 0) begin
            r.read = 1'b1;
        end else begin
`ifdef STORE_BUFFER_FWD_EN
            if (model_q[hit_idx].addr == la && model_q[hit_idx].f3 == lf) begin
                r.hit  = 1'b1;
                r.data = (lf == 3'b011) ? model_q[hit_idx].data : {32'd0, model_q[hit_idx].data[31:0]};
            end else
`endif
                r.stall = 1'b1;
        end
        return r;
    endfunction

    // One cycle: called at posedge+1, drives inputs, records expectations, returns at next posedge+1.
    task automatic step(input bit sv, input logic [63:0] sa, input logic [63:0] sd, input logic [2:0] sf,
                        input bit lv, input logic [63:0] la, input logic [2:0] lf);
        bit full;
        st_valid = sv; st_addr = sa; st_data = sd; st_funct3 = sf;
        ld_valid = lv; ld_addr = la; ld_funct3 = lf;
        full = (model_q.size() == DEPTH);
        chk("st_ready", 64'(st_ready), 64'(!full));
        if (lv) ld_q.push_back(predict_load(sv, la, lf));
        else if (model_q.size() > 0) wr_q.push_back(model_q.pop_front());
        if (sv && !full && (sf == 3'b010 || sf == 3'b011))
            model_q.push_back('{addr: sa, data: sd, f3: sf});
        @(posedge clk);
        #1;
        chk("count", 64'(count), 64'(model_q.size()));
        chk("empty", 64'(empty), 64'(model_q.size() == 0));
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 3'b000, 1'b0, '0, 3'b000);
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r < 12) return 64'(4 * $urandom_range(0, 7));
        if (r < 14) return 64'($urandom_range(0, 31));
        return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
    endfunction

    function automatic logic [2:0] rand_f3();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 3'($urandom_range(0, 7));
        return (r < 5) ? 3'b010 : 3'b011;
    endfunction

    // Monitor: compares every presented load response and memory write against the scoreboard.
    initial begin
        ld_t le;
        st_t we;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ld_valid) begin
                    if (ld_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ld_unexpected: got load response with no expectation at %0t", $time);
                    end else begin
                        le = ld_q.pop_front();
                        chk("ld_hit", 64'(ld_hit), 64'(le.hit));
                        chk("ld_stall", 64'(ld_stall), 64'(le.stall));
                        chk("mem_read", 64'(mem_read), 64'(le.read));
                        chk("ld_hit_data", ld_hit_data, le.data);
                        chk("ld_mem_addr", mem_addr, le.addr);
                        chk("ld_mem_funct3", 64'(mem_funct3), 64'(le.f3));
                        chk("ld_mem_write", 64'(mem_write), 64'(0));
                    end
                end
                if (mem_write) begin
                    if (wr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wr_unexpected: got write addr %h expected none at %0t", mem_addr, $time);
                    end else begin
                        we = wr_q.pop_front();
                        chk("wr_addr", mem_addr, we.addr);
                        chk("wr_data", mem_wdata, we.data);
                        chk("wr_funct3", 64'(mem_funct3), 64'(we.f3));
                    end
                end else if (wr_q.size() != 0) begin
                    we = wr_q.pop_front();
                    checks++; errors++;
                    $display("FAIL wr_missing: got no write expected addr %h at %0t", we.addr, $time);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        st_valid = 0; st_addr = '0; st_data = '0; st_funct3 = '0;
        ld_valid = 0; ld_addr = '0; ld_funct3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_st_ready", 64'(st_ready), 64'(1));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_mem_write", 64'(mem_write), 64'(0));
        chk("rst_mem_read", 64'(mem_read), 64'(0));
        chk("rst_ld_hit", 64'(ld_hit), 64'(0));
        chk("rst_ld_stall", 64'(ld_stall), 64'(0));
        chk("rst_mem_addr", mem_addr, 64'(0));
        chk("rst_mem_wdata", mem_wdata, 64'(0));
        chk("rst_ld_hit_data", ld_hit_data, 64'(0));
        reset = 1'b0;

        // sd then drain
        step(1, 64'h10, 64'h1122334455667788, 3'b011, 0, '0, 3'b000);
        idle();
        // sw then forwarded lw
        step(1, 64'h20, 64'h00000000DEADBEEF, 3'b010, 0, '0, 3'b000);
        step(0, '0, '0, 3'b000, 1, 64'h20, 3'b010);
        idle();
        // partial overlap: held load stalls, drain, reissue reads memory
        step(1, 64'h8, 64'hA5A5A5A5_5A5A5A5A, 3'b011, 0, '0, 3'b000);
        repeat (3) step(0, '0, '0, 3'b000, 1, 64'hC, 3'b010);
        idle();
        step(0, '0, '0, 3'b000, 1, 64'hC, 3'b010);
        // fill with load held, fifth store held off, drain in order
        for (int i = 0; i < 5; i++) step(1, 64'h100 + 64'(8 * i), 64'(i + 1), 3'b011, 1, 64'h400, 3'b011);
        repeat (4) idle();
        // full, one drain, then simultaneous enqueue+drain (6 stores wrap the pointers)
        for (int i = 0; i < 4; i++) step(1, 64'h200 + 64'(4 * i), 64'(i + 10), 3'b010, 1, 64'h400, 3'b010);
        idle();
        step(1, 64'h240, 64'h77, 3'b011, 0, '0, 3'b000);
        step(1, 64'h248, 64'h88, 3'b011, 0, '0, 3'b000);
        repeat (4) idle();
        // async reset with three entries pending
        for (int i = 0; i < 3; i++) step(1, 64'h300 + 64'(8 * i), 64'(i), 3'b011, 1, 64'h500, 3'b011);
        st_valid = 0; ld_valid = 0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", 64'(count), 64'(0));
        chk("async_rst_mem_write", 64'(mem_write), 64'(0));
        model_q.delete();
        wr_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) idle();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            bit sv, lv;
            sv = ($urandom_range(0, 99) < 40);
            lv = ($urandom_range(0, 99) < 50);
            step(sv, rand_addr(), {$urandom, $urandom}, rand_f3(), lv, rand_addr(), rand_f3());
        end
        for (int n = 0; n < 2 * DEPTH && model_q.size() > 0; n++) idle();
        idle();
        chk("final_model_empty", 64'(model_q.size()), 64'(0));
        chk("final_wr_q", 64'(wr_q.size()), 64'(0));
        chk("final_ld_q", 64'(ld_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
